// File: rtl/full_subtractor.sv
// Registered ripple-borrow full subtractor: {bin, diff} = a - b - bout.
// A chain of WIDTH one-bit full-subtractor cells feeds a single output
// register stage; out_valid is in_valid delayed by one cycle.
// Optional macro FULL_SUBTRACTOR_ZERO_FLAG_EN adds a registered 'zero' flag
// that is set when the captured difference is all zeros.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bout,
  output logic [WIDTH-1:0] diff,
  output logic             bin,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             out_valid
`ifdef FULL_SUBTRACTOR_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  // One full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic ci);
    logic d;
    logic c;
    d = ai ^ bi ^ ci;
    c = (~ai & bi) | (~(ai ^ bi) & ci);
    return {c, d};
  endfunction

  logic [WIDTH:0]   c_p0;
  logic [WIDTH-1:0] d_p0;

  // ---- Stage p0: combinational ripple-borrow chain, LSB cell takes bout ----
  always_comb begin
    c_p0    = '0;
    d_p0    = '0;
    c_p0[0] = bout;
    for (int i = 0; i < WIDTH; i++) begin
      {c_p0[i+1], d_p0[i]} = fs_cell(a[i], b[i], c_p0[i]);
    end
  end

  // ---- Stage p1: output register; result loads only on accepted inputs ----
  // Capture result when in_valid, hold otherwise; out_valid follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff      <= '0;
      bin       <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_SUBTRACTOR_ZERO_FLAG_EN
      zero      <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff <= d_p0;
        bin  <= c_p0[WIDTH];
`ifdef FULL_SUBTRACTOR_ZERO_FLAG_EN
        zero <= (d_p0 == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor: a WIDTH=1 and a WIDTH=8 instance share
// clock and reset. Inputs change on the falling edge; outputs are checked on
// the falling edge (or shortly after the rising edge), away from capture.
module tb_full_subtractor;

  logic       clk;
  logic       rst_n;

  logic [0:0] a1, b1, d1;
  logic       bo1, bi1, iv1, ov1;

  logic [7:0] a8, b8, d8;
  logic       bo8, bi8, iv8, ov8;
`ifdef FULL_SUBTRACTOR_ZERO_FLAG_EN
  logic       z1, z8;
`endif

  int checks   = 0;
  int failures = 0;

  full_subtractor #(.WIDTH(1)) dut1 (
    .a(a1), .b(b1), .bout(bo1), .diff(d1), .bin(bi1),
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .out_valid(ov1)
`ifdef FULL_SUBTRACTOR_ZERO_FLAG_EN
    , .zero(z1)
`endif
  );

  full_subtractor #(.WIDTH(8)) dut8 (
    .a(a8), .b(b8), .bout(bo8), .diff(d8), .bin(bi8),
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .out_valid(ov8)
`ifdef FULL_SUBTRACTOR_ZERO_FLAG_EN
    , .zero(z8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    iv1 = 1'b1; iv8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a1 = 1'($urandom); b1 = 1'($urandom); bo1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); bo8 = 1'($urandom);
    end
    @(negedge clk);
    checks++;
    if ({d8, bi8, ov8} !== 10'b0) begin
      failures++;
      $display("FAIL reset_hold_w8: got diff=%h bin=%b ov=%b, want 00 0 0", d8, bi8, ov8);
    end
    checks++;
    if ({d1, bi1, ov1} !== 3'b0) begin
      failures++;
      $display("FAIL reset_hold_w1: got diff=%b bin=%b ov=%b, want 0 0 0", d1, bi1, ov1);
    end
    iv1 = 1'b0; iv8 = 1'b0;
    rst_n = 1'b1;
    // Capture a value, then assert reset between edges.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bo8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #2;
    iv8 = 1'b0;
    checks++;
    if ({d8, bi8, ov8} !== {8'h0F, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL pre_async_reset: got diff=%h bin=%b ov=%b, want 0f 0 1", d8, bi8, ov8);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d8, bi8, ov8} !== 10'b0) begin
      failures++;
      $display("FAIL async_reset: got diff=%h bin=%b ov=%b, want 00 0 0", d8, bi8, ov8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] tt [8];
    logic [2:0] v;
    tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({d1, bi1, ov1} !== {tt[i-1], 1'b1}) begin
          failures++;
          $display("FAIL truth_table[%0d]: got diff=%b bin=%b ov=%b, want %b%b 1",
                   i - 1, d1, bi1, ov1, tt[i-1][1], tt[i-1][0]);
        end
      end
      if (i < 8) begin
        v = 3'(i);
        {a1, b1, bo1} = v;
        iv1 = 1'b1;
      end else begin
        iv1 = 1'b0;
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; bo1 = 1'b0; iv1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({d1, bi1, ov1} !== 3'b101) begin
      failures++;
      $display("FAIL hold_capture: got diff=%b bin=%b ov=%b, want 1 0 1", d1, bi1, ov1);
    end
    a1 = 1'b0; b1 = 1'b1; bo1 = 1'b1; iv1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({d1, bi1, ov1} !== 3'b100) begin
        failures++;
        $display("FAIL hold_idle[%0d]: got diff=%b bin=%b ov=%b, want 1 0 0", k, d1, bi1, ov1);
      end
    end
  endtask

  task automatic test_width8_directed();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    logic [7:0] ed [4];
    logic       eb [4];
    va = '{8'h00, 8'hFF, 8'h00, 8'h5A};
    vb = '{8'h01, 8'h00, 8'h00, 8'h5A};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0};
    ed = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    eb = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a8 = va[i]; b8 = vb[i]; bo8 = vc[i]; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      checks++;
      if ({d8, bi8, ov8} !== {ed[i], eb[i], 1'b1}) begin
        failures++;
        $display("FAIL w8_case[%0d]: got diff=%h bin=%b ov=%b, want %h %b 1",
                 i, d8, bi8, ov8, ed[i], eb[i]);
      end
`ifdef FULL_SUBTRACTOR_ZERO_FLAG_EN
      checks++;
      if (z8 !== (i == 3)) begin
        failures++;
        $display("FAIL w8_zero[%0d]: got zero=%b, want %b", i, z8, (i == 3));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    logic [8:0] prev;
    logic       pend;
    pend = 1'b0;
    prev = '0;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (pend) begin
        checks++;
        if ({bi8, d8, ov8} !== {prev, 1'b1}) begin
          failures++;
          $display("FAIL stream[%0d]: got bin=%b diff=%h ov=%b, want %b %h 1",
                   i - 1, bi8, d8, ov8, prev[8], prev[7:0]);
        end
      end
      if (i == 50) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bi8, d8, ov8} !== 10'b0) begin
          failures++;
          $display("FAIL stream_reset: got bin=%b diff=%h ov=%b, want 0 00 0", bi8, d8, ov8);
        end
        rst_n = 1'b1;
        iv8 = 1'b0;
        @(negedge clk);
        checks++;
        if (ov8 !== 1'b0) begin
          failures++;
          $display("FAIL stream_post_reset: got ov=%b, want 0", ov8);
        end
      end
      if (i < 100) begin
        a8 = 8'($urandom); b8 = 8'($urandom); bo8 = 1'($urandom);
        iv8 = 1'b1;
        exp = {1'b0, a8} - {1'b0, b8} - {8'b0, bo8};
        prev = exp;
        pend = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain: got ov=%b, want 0", ov8);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = '0; b1 = '0; bo1 = 1'b0; iv1 = 1'b0;
    a8 = '0; b8 = '0; bo8 = 1'b0; iv8 = 1'b0;
    test_reset();
    test_truth_table();
    test_hold();
    test_width8_directed();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
